// File: rtl/pipe_pkg.sv
// Shared stage indices and the per-stage writeback descriptor for the pipeline controller.
package pipe_pkg;

  localparam int ST_IF  = 0;
  localparam int ST_ID  = 1;
  localparam int ST_EX  = 2;
  localparam int ST_MEM = 3;
  localparam int ST_WB  = 4;

  // Descriptor dest field is sized for the widest register file we expect; narrower
  // register numbers are zero-extended into it.
  localparam int DESC_RW_MAX = 8;

  typedef struct packed {
    logic                   we;
    logic                   late;
    logic [DESC_RW_MAX-1:0] dest;
  } wb_desc_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake, descriptor and hazard bundle between the datapath and pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
  parameter int NSTAGE = 5,
  parameter int RW     = 5,
  parameter int CNTW   = 32,
  parameter int SW     = $clog2(NSTAGE)
);
  logic              in_valid;
  logic [NSTAGE-1:0] ready_go;
  logic [NSTAGE-1:0] flush_vec;
  logic              id_gr_we;
  logic              id_late;
  logic [RW-1:0]     id_dest;
  logic [RW-1:0]     id_src1;
  logic [RW-1:0]     id_src2;
  logic              id_use1;
  logic              id_use2;
  logic [NSTAGE-1:0] stage_valid;
  logic [NSTAGE-1:0] allowin;
  logic [NSTAGE-1:0] load;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [SW-1:0]     fwd_sel1;
  logic [SW-1:0]     fwd_sel2;
  logic              id_stall;
  logic [CNTW-1:0]   retire_cnt;
  logic [CNTW-1:0]   stall_cnt;

  modport master (
    output in_valid, ready_go, flush_vec, id_gr_we, id_late, id_dest,
           id_src1, id_src2, id_use1, id_use2,
    input  stage_valid, allowin, load, fwd_hit1, fwd_hit2, fwd_sel1, fwd_sel2,
           id_stall, retire_cnt, stall_cnt
  );

  modport slave (
    input  in_valid, ready_go, flush_vec, id_gr_we, id_late, id_dest,
           id_src1, id_src2, id_use1, id_use2,
    output stage_valid, allowin, load, fwd_hit1, fwd_hit2, fwd_sel1, fwd_sel2,
           id_stall, retire_cnt, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_match.sv
// Priority forwarding match for one decode source over the EX..WB descriptors;
// the youngest (lowest stage index) matching producer wins.
module fwd_match
  import pipe_pkg::*;
#(
  parameter int NENT = 3,
  parameter int BASE = 2,
  parameter int RW   = 5,
  parameter int SW   = 3
) (
  input  logic [NENT-1:0] i_valid,
  input  wb_desc_t        i_desc [NENT],
  input  logic [RW-1:0]   i_src,
  input  logic            i_use,
  output logic            o_hit,
  output logic [SW-1:0]   o_sel,
  output logic            o_late
);

  logic [NENT-1:0] w_match;

  genvar gi;
  generate
    for (gi = 0; gi < NENT; gi++) begin : g_match
      assign w_match[gi] = i_valid[gi] & i_desc[gi].we & i_use & (i_src != '0) &
                           (i_desc[gi].dest == DESC_RW_MAX'(i_src));
    end
  endgenerate

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    o_hit  = 1'b0;
    o_sel  = '0;
    o_late = 1'b0;
    for (int k = NENT - 1; k >= 0; k--) begin
      if (w_match[k]) begin
        o_hit  = 1'b1;
        o_sel  = SW'(BASE + k);
        o_late = i_desc[k].late;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline valid/allowin chain, per-stage flush, writeback descriptors, forwarding
// selects, load-use stall for decode, and retire/stall performance counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NSTAGE     = 5,
  parameter int RW         = 5,
  parameter int LATE_STAGE = 3,
  parameter int CNTW       = 32,
  parameter int SW         = $clog2(NSTAGE)
) (
  input  logic               clk,
  input  logic               resetn,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int NDESC = NSTAGE - ST_EX;

  logic [NSTAGE-1:0] r_valid;
  wb_desc_t          r_desc [NDESC];  // entry k describes stage k + ST_EX
  logic [CNTW-1:0]   r_retire_cnt;
  logic [CNTW-1:0]   r_stall_cnt;

  logic [NSTAGE-1:0] w_rg;
  logic [NSTAGE-1:0] w_to_next;
  logic [NSTAGE-1:0] w_allowin;
  logic [NSTAGE-1:0] w_load;
  logic [NSTAGE-1:0] w_valid_next;
  wb_desc_t          w_desc_next [NDESC];
  wb_desc_t          w_id_desc;
  logic              w_hit1, w_hit2;
  logic              w_late1, w_late2;
  logic [SW-1:0]     w_sel1, w_sel2;
  logic              w_id_stall;

  assign w_id_desc = '{we: bus.id_gr_we, late: bus.id_late, dest: DESC_RW_MAX'(bus.id_dest)};

  fwd_match #(.NENT(NDESC), .BASE(ST_EX), .RW(RW), .SW(SW)) u_fwd1 (
    .i_valid (r_valid[NSTAGE-1:ST_EX]),
    .i_desc  (r_desc),
    .i_src   (bus.id_src1),
    .i_use   (bus.id_use1),
    .o_hit   (w_hit1),
    .o_sel   (w_sel1),
    .o_late  (w_late1)
  );

  fwd_match #(.NENT(NDESC), .BASE(ST_EX), .RW(RW), .SW(SW)) u_fwd2 (
    .i_valid (r_valid[NSTAGE-1:ST_EX]),
    .i_desc  (r_desc),
    .i_src   (bus.id_src2),
    .i_use   (bus.id_use2),
    .o_hit   (w_hit2),
    .o_sel   (w_sel2),
    .o_late  (w_late2)
  );

  // A late result is not yet available while its producer sits before LATE_STAGE.
  assign w_id_stall = r_valid[ST_ID] &
                      ((w_hit1 & w_late1 & (int'(w_sel1) < LATE_STAGE)) |
                       (w_hit2 & w_late2 & (int'(w_sel2) < LATE_STAGE)));

  always_comb begin
    w_rg        = bus.ready_go;
    w_rg[ST_ID] = bus.ready_go[ST_ID] & ~w_id_stall;
  end

  assign w_to_next = r_valid & w_rg;

  always_comb begin
    w_allowin             = '0;
    w_allowin[NSTAGE-1]   = ~r_valid[NSTAGE-1] | w_rg[NSTAGE-1];
    for (int i = NSTAGE - 2; i >= 0; i--) begin
      w_allowin[i] = ~r_valid[i] | (w_rg[i] & w_allowin[i+1]);
    end
  end

  assign w_load = w_allowin & ~bus.flush_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NSTAGE; gi++) begin : g_valid
      logic w_up;
      if (gi == ST_IF) begin : g_head
        assign w_up = bus.in_valid;
      end else begin : g_body
        assign w_up = w_to_next[gi-1];
      end
      // Flush wins over both load and hold; a stalled ID leaves a bubble behind it.
      assign w_valid_next[gi] = bus.flush_vec[gi] ? 1'b0 :
                                (w_allowin[gi] ? w_up : r_valid[gi]);
    end

    for (gi = 0; gi < NDESC; gi++) begin : g_desc
      wb_desc_t w_up;
      if (gi == 0) begin : g_head
        assign w_up = w_id_desc;
      end else begin : g_body
        assign w_up = r_desc[gi-1];
      end
      assign w_desc_next[gi] = w_load[gi+ST_EX] ? w_up : r_desc[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid      <= '0;
      r_retire_cnt <= '0;
      r_stall_cnt  <= '0;
      for (int k = 0; k < NDESC; k++) begin
        r_desc[k] <= '0;
      end
    end else begin
      r_valid      <= w_valid_next;
      r_retire_cnt <= r_retire_cnt + CNTW'(w_to_next[NSTAGE-1]);
      r_stall_cnt  <= r_stall_cnt + CNTW'(w_id_stall);
      for (int k = 0; k < NDESC; k++) begin
        r_desc[k] <= w_desc_next[k];
      end
    end
  end

  assign bus.stage_valid = r_valid;
  assign bus.allowin     = w_allowin;
  assign bus.load        = w_load;
  assign bus.fwd_hit1    = w_hit1;
  assign bus.fwd_hit2    = w_hit2;
  assign bus.fwd_sel1    = w_sel1;
  assign bus.fwd_sel2    = w_sel2;
  assign bus.id_stall    = w_id_stall;
  assign bus.retire_cnt  = r_retire_cnt;
  assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a per-cycle behavioural pipeline model checks
// every output on each falling edge, and literal checks pin the key scenarios.
module tb_pipe_hazard_ctrl;

  localparam int NS = 5;
  localparam int CW = 8;
  localparam int LS = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NSTAGE(NS), .RW(5), .CNTW(CW)) bus ();

  pipe_hazard_ctrl #(.NSTAGE(NS), .RW(5), .LATE_STAGE(LS), .CNTW(CW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: occupancy and writeback descriptor per stage, plus counters.
  bit             m_known = 1'b0;
  bit             mv    [NS];
  bit             mwe   [NS];
  bit             mlate [NS];
  logic [4:0]     mdest [NS];
  logic [CW-1:0]  mret;
  logic [CW-1:0]  mstall;

  function automatic void find_src(input logic [4:0] src, input bit use_s,
                                   output bit hit, output int sel, output bit late);
    hit = 1'b0; sel = 0; late = 1'b0;
    for (int i = 2; i < NS; i++) begin
      if (mv[i] && mwe[i] && mdest[i] == src && src != 0 && use_s) begin
        hit = 1'b1; sel = i; late = mlate[i];
        break;
      end
    end
  endfunction

  initial begin : model
    bit h1, h2, l1, l2, stall, up;
    int s1, s2;
    bit rdy [NS];
    bit acc [NS];
    bit nv [NS], nwe [NS], nlate [NS];
    logic [4:0] ndest [NS];
    logic [NS-1:0] e_allow, e_load, e_valid;
    logic [CW-1:0] nret, nstall;
    forever begin
      @(negedge clk);
      find_src(bus.id_src1, bus.id_use1, h1, s1, l1);
      find_src(bus.id_src2, bus.id_use2, h2, s2, l2);
      stall = mv[1] && ((h1 && l1 && s1 < LS) || (h2 && l2 && s2 < LS));
      for (int i = 0; i < NS; i++) rdy[i] = bus.ready_go[i] && !(i == 1 && stall);
      // A stage can accept when the run of full, ready stages below it ends in a hole or in retirement.
      for (int i = 0; i < NS; i++) begin
        acc[i] = 1'b1;
        for (int j = i; j < NS; j++) begin
          if (!mv[j]) break;
          if (!rdy[j]) begin acc[i] = 1'b0; break; end
        end
      end
      for (int i = 0; i < NS; i++) begin
        e_allow[i] = acc[i];
        e_load[i]  = acc[i] && !bus.flush_vec[i];
        e_valid[i] = mv[i];
      end
      if (m_known) begin
        check("m_valid",  bus.stage_valid, e_valid);
        check("m_allow",  bus.allowin, e_allow);
        check("m_load",   bus.load, e_load);
        check("m_hit1",   bus.fwd_hit1, h1);
        check("m_sel1",   bus.fwd_sel1, s1);
        check("m_hit2",   bus.fwd_hit2, h2);
        check("m_sel2",   bus.fwd_sel2, s2);
        check("m_stall",  bus.id_stall, stall);
        check("m_retire", bus.retire_cnt, mret);
        check("m_stcnt",  bus.stall_cnt, mstall);
      end
      for (int i = 0; i < NS; i++) begin
        up = (i == 0) ? bus.in_valid : (mv[i-1] && rdy[i-1]);
        nv[i] = bus.flush_vec[i] ? 1'b0 : (acc[i] ? up : mv[i]);
        nwe[i] = mwe[i]; nlate[i] = mlate[i]; ndest[i] = mdest[i];
        if (i >= 2 && e_load[i]) begin
          if (i == 2) begin
            nwe[i] = bus.id_gr_we; nlate[i] = bus.id_late; ndest[i] = bus.id_dest;
          end else begin
            nwe[i] = mwe[i-1]; nlate[i] = mlate[i-1]; ndest[i] = mdest[i-1];
          end
        end
      end
      nret   = mret + ((mv[NS-1] && rdy[NS-1]) ? 1 : 0);
      nstall = mstall + (stall ? 1 : 0);
      if (!resetn) begin
        for (int i = 0; i < NS; i++) begin
          nv[i] = 0; nwe[i] = 0; nlate[i] = 0; ndest[i] = '0;
        end
        nret = '0; nstall = '0;
        m_known = 1'b1;
      end
      @(posedge clk);
      for (int i = 0; i < NS; i++) begin
        mv[i] = nv[i]; mwe[i] = nwe[i]; mlate[i] = nlate[i]; mdest[i] = ndest[i];
      end
      mret = nret; mstall = nstall;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [CW-1:0] base;
    int guard;
    bus.in_valid = 0; bus.ready_go = '1; bus.flush_vec = '0;
    bus.id_gr_we = 0; bus.id_late = 0; bus.id_dest = '0;
    bus.id_src1 = '0; bus.id_src2 = '0; bus.id_use1 = 0; bus.id_use2 = 0;
    resetn = 0;
    tick(); tick();
    resetn = 1;
    #1;
    check("rst_valid",  bus.stage_valid, 5'b00000);
    check("rst_allow",  bus.allowin, 5'b11111);
    check("rst_stall",  bus.id_stall, 0);
    check("rst_hit1",   bus.fwd_hit1, 0);
    check("rst_sel1",   bus.fwd_sel1, 0);
    check("rst_retire", bus.retire_cnt, 0);
    check("rst_stcnt",  bus.stall_cnt, 0);

    // Fill the pipe, then see the first retirement.
    bus.in_valid = 1;
    for (int k = 1; k <= NS; k++) begin
      tick(); #1;
      check("fill_valid", bus.stage_valid, (1 << k) - 1);
    end
    check("fill_ret_pre", bus.retire_cnt, 0);
    tick(); #1;
    check("fill_ret_1", bus.retire_cnt, 1);

    // Plain forwarding from EX, then youngest-wins with EX and MEM both writing r4.
    bus.id_gr_we = 1; bus.id_dest = 4; bus.id_late = 0;
    tick();
    bus.id_src1 = 4; bus.id_use1 = 1;
    #1;
    check("fwd_ex_hit", bus.fwd_hit1, 1);
    check("fwd_ex_sel", bus.fwd_sel1, 2);
    check("fwd_ex_stall", bus.id_stall, 0);
    tick();
    bus.id_gr_we = 0; bus.id_src2 = 4; bus.id_use2 = 0;
    #1;
    check("fwd_young_hit", bus.fwd_hit1, 1);
    check("fwd_young_sel", bus.fwd_sel1, 2);
    check("fwd_nouse_hit2", bus.fwd_hit2, 0);
    tick();
    bus.id_use1 = 0; bus.id_src1 = '0; bus.id_src2 = '0;
    tick(); tick(); tick();

    // Load-use: one stall cycle, bubble into EX, then forward from MEM.
    bus.id_gr_we = 1; bus.id_dest = 5; bus.id_late = 1;
    tick();
    bus.id_gr_we = 0; bus.id_late = 0; bus.id_src1 = 5; bus.id_use1 = 1;
    #1;
    check("ldu_stall", bus.id_stall, 1);
    check("ldu_allow", bus.allowin, 5'b11100);
    check("ldu_sel_ex", bus.fwd_sel1, 2);
    check("ldu_stcnt0", bus.stall_cnt, 0);
    tick(); #1;
    check("ldu_nostall", bus.id_stall, 0);
    check("ldu_sel_mem", bus.fwd_sel1, 3);
    check("ldu_hit_mem", bus.fwd_hit1, 1);
    check("ldu_stcnt1", bus.stall_cnt, 1);
    check("ldu_bubble", bus.stage_valid, 5'b11011);
    bus.id_use1 = 0; bus.id_src1 = '0;
    tick(); tick(); tick(); tick();

    // Register 0 never forwards, even from a late producer.
    bus.id_gr_we = 1; bus.id_dest = 0; bus.id_late = 1;
    tick();
    bus.id_gr_we = 0; bus.id_late = 0; bus.id_src1 = 0; bus.id_use1 = 1;
    #1;
    check("r0_hit", bus.fwd_hit1, 0);
    check("r0_stall", bus.id_stall, 0);
    bus.id_use1 = 0;
    tick();

    // Flush IF on a full pipe; the hole costs exactly one retirement slot.
    #1;
    check("fl_full", bus.stage_valid, 5'b11111);
    bus.flush_vec = 5'b00001;
    tick();
    bus.flush_vec = '0;
    #1;
    check("fl_valid", bus.stage_valid, 5'b11110);
    base = mret + CW'(4);
    for (int k = 0; k < 5; k++) tick();
    #1;
    check("fl_retire", bus.retire_cnt, base);

    // Backpressure from WB freezes everything.
    check("bp_full", bus.stage_valid, 5'b11111);
    bus.ready_go = 5'b01111;
    #1;
    check("bp_allow", bus.allowin, 5'b00000);
    check("bp_load", bus.load, 5'b00000);
    base = mret;
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      check("bp_valid", bus.stage_valid, 5'b11111);
      check("bp_retire", bus.retire_cnt, base);
    end
    bus.ready_go = '1;
    tick(); #1;
    check("bp_resume1", bus.retire_cnt, base + CW'(1));
    tick(); #1;
    check("bp_resume2", bus.retire_cnt, base + CW'(2));

    // Retire counter wraps to zero.
    guard = 0;
    while (bus.retire_cnt != {CW{1'b1}} && guard < 400) begin
      tick();
      guard++;
    end
    check("wrap_reached", guard < 400, 1);
    tick(); #1;
    check("wrap_zero", bus.retire_cnt, 0);

    // Flushing a stalled ID still counts the stall cycle.
    bus.id_gr_we = 1; bus.id_dest = 6; bus.id_late = 1;
    tick();
    bus.id_gr_we = 0; bus.id_late = 0; bus.id_src2 = 6; bus.id_use2 = 1;
    bus.flush_vec = 5'b00010;
    #1;
    check("fs_stall", bus.id_stall, 1);
    check("fs_hit2", bus.fwd_hit2, 1);
    check("fs_sel2", bus.fwd_sel2, 2);
    base = mstall + CW'(1);
    tick();
    bus.flush_vec = '0; bus.id_use2 = 0; bus.id_src2 = '0;
    #1;
    check("fs_stcnt", bus.stall_cnt, base);
    check("fs_valid", bus.stage_valid, 5'b11001);

    // Reset in mid-flight drops everything with no partial retire.
    tick(); tick();
    resetn = 0;
    tick();
    resetn = 1;
    #1;
    check("mrst_valid", bus.stage_valid, 5'b00000);
    check("mrst_retire", bus.retire_cnt, 0);
    check("mrst_stcnt", bus.stall_cnt, 0);
    check("mrst_allow", bus.allowin, 5'b11111);
    bus.in_valid = 0;
    tick(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
